smem_update_ctrl: RTL and testbench
===================================

Name: smem_update_ctrl

Overview:
- Owns the single read/write port of the screen (character-code) memory in the 640x480 text/sprite display path.
- Arbitrates CPU store requests against an internal block engine that performs CLEAR (fill the whole screen) and SCROLL (move rows up one and fill the bottom row).
- The display read port is independent and not touched by this block.

Parameters:
- Nchars, 4, number of character codes; the data width is $clog2(Nchars).
- smem_size, 1200, number of screen memory entries (30 rows x 40 cols).
- ncols, 40, entries per row (640 / sprite_size).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU write request; held until cpu_gnt.
- cpu_addr  in  $clog2(smem_size)  CPU write address.
- cpu_wdata  in  $clog2(Nchars)  CPU write data.
- cpu_gnt  out  1  high in the cycle the CPU write is issued to memory.
- cmd_valid  in  1  engine command valid.
- cmd_op  in  1  0=CLEAR, 1=SCROLL.
- cmd_fill  in  $clog2(Nchars)  fill character code.
- cmd_ready  out  1  high when the engine is in IDLE.
- busy  out  1  engine not IDLE.
- done  out  1  one-cycle pulse when a command completes.
- mem_addr  out  $clog2(smem_size)  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  $clog2(Nchars)  memory write data.
- mem_rdata  in  $clog2(Nchars)  read data, valid exactly 1 cycle after address with mem_we=0.

Behaviour:
- Reset values:
  - engine goes to IDLE.
  - cpu_gnt=0, busy=0, done=0, cmd_ready=1.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - All counters and registers cleared.
- Command acceptance:
  - A command is accepted on cmd_valid && cmd_ready.
  - cmd_op and cmd_fill are latched.
  - busy rises the next cycle.
- Engine states:
  - IDLE: on accept, go to CLR_WR (op=0, ptr=0) or SC_RD (op=1, ptr=0).
  - CLR_WR: write fill to ptr.
    - On a granted slot: if ptr=smem_size-1, go to DONE; else ptr+1.
  - SC_RD: issue a read of ptr+ncols. On a granted slot, go to SC_WR.
    - The hold register captures mem_rdata in the cycle after the read slot, unconditionally.
  - SC_WR: write the hold register to ptr.
    - On a granted slot: if ptr=smem_size-ncols-1, set ptr=smem_size-ncols and go to FILL; else ptr+1 and return to SC_RD.
  - FILL: write fill to ptr.
    - On a granted slot: if ptr=smem_size-1, go to DONE; else ptr+1.
  - DONE: done=1 for one cycle, then IDLE.
  - Commands arriving while busy are not accepted (cmd_ready=0).
- Arbitration (default):
  - CPU has strict priority: cpu_gnt = cpu_req in every cycle.
  - The engine gets the slot only when cpu_req=0.
  - The port is combinationally driven by the slot owner; when no one owns it, mem_we=0.
  - CPU grant latency is 0 cycles.
  - An engine stall freezes state and ptr.
  - A CPU write between an engine read and the hold capture does not corrupt the hold register (reads are registered by memory).
- CPU write hazard during SCROLL: CPU writes are applied in grant order, with no ordering guarantee relative to the scroll.
- Ptr width is $clog2(smem_size); address arithmetic never exceeds smem_size-1.
- Reset mid-command aborts immediately: IDLE, no done pulse.

Optional Feature:
- Macro: SMEM_FAIR_EN.
- Defined: round-robin arbitration. After a CPU grant, if the engine requests the next slot, the engine wins that slot. The CPU then waits at most 1 cycle, and the engine is never starved.
- Undefined: CPU strict priority as above. The engine may starve under continuous cpu_req.

Decomposition:
- Package smem_pkg:
  - typedef engine_state_t {IDLE, CLR_WR, SC_RD, SC_WR, FILL, DONE}.
  - localparams SMEM_ABITS and CHAR_BITS.
  - enum op_t {OP_CLEAR, OP_SCROLL}.
- Sub-module smem_port_arbiter: 2-requester arbiter with the SMEM_FAIR_EN variant, producing grant and port mux select.
- The engine FSM stays in the top module.

Test Plan:
- Reset with cmd_valid=1 held -> after reset release, cmd_ready=1, busy=0, mem_we=0; command accepted the first cycle after release.
- CLEAR, fill=2, no CPU traffic -> 1200 consecutive writes at addr 0..1199 with data 2; done pulses exactly once, 1202 cycles after accept.
- SCROLL on memory preloaded mem[i]=i%4, fill=3 -> mem[i]=(i+40)%4 for i<1160 and mem[1160..1199]=3; 2*1160+40 granted slots.
- SCROLL with cpu_req held 10 cycles mid-command (addr 5, data 1) -> engine frozen for 10 cycles, cpu_gnt=1 each cycle, scroll result otherwise identical.
- With SMEM_FAIR_EN, cpu_req held constantly during CLEAR -> grants alternate CPU/engine; CLEAR completes in about 2400 cycles. Without the macro, the engine makes no progress.
- Reset asserted at ptr=500 of SCROLL -> IDLE next cycle, no done pulse, a new CLEAR accepted and completing correctly.

Source files
------------

// File: rtl/smem_update_ctrl_pkg.sv
// Shared types and sizes for the screen-memory update controller.
// Optional SMEM_FAIR_EN selects round-robin port arbitration (see smem_port_arbiter).
package smem_pkg;

  localparam int NCHARS     = 4;
  localparam int SMEM_SIZE  = 1200;
  localparam int NCOLS      = 40;
  localparam int SMEM_ABITS = $clog2(SMEM_SIZE);
  localparam int CHAR_BITS  = $clog2(NCHARS);

  typedef enum logic [2:0] {
    IDLE,
    CLR_WR,
    SC_RD,
    SC_WR,
    FILL,
    DONE
  } engine_state_t;

  typedef enum logic {
    OP_CLEAR  = 1'b0,
    OP_SCROLL = 1'b1
  } op_t;

endpackage

// File: rtl/smem_update_ctrl_if.sv
// CPU write port, engine command/status and screen-memory port of smem_update_ctrl.
// master = environment side, slave = controller side.
interface smem_update_ctrl_if
  import smem_pkg::*;
#(
  parameter int ABITS = SMEM_ABITS,
  parameter int CBITS = CHAR_BITS
) ();

  logic             cpu_req;
  logic [ABITS-1:0] cpu_addr;
  logic [CBITS-1:0] cpu_wdata;
  logic             cpu_gnt;

  logic             cmd_valid;
  logic             cmd_op;
  logic [CBITS-1:0] cmd_fill;
  logic             cmd_ready;
  logic             busy;
  logic             done;

  logic [ABITS-1:0] mem_addr;
  logic             mem_we;
  logic [CBITS-1:0] mem_wdata;
  logic [CBITS-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cmd_valid, cmd_op, cmd_fill, mem_rdata,
    input  cpu_gnt, cmd_ready, busy, done, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cmd_valid, cmd_op, cmd_fill, mem_rdata,
    output cpu_gnt, cmd_ready, busy, done, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/smem_port_arbiter.sv
// Two-requester arbiter for the screen-memory port (CPU vs block engine).
// Default: CPU strict priority. With SMEM_FAIR_EN: engine wins the slot right after a CPU grant.
module smem_port_arbiter (
`ifdef SMEM_FAIR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic cpu_req,
  input  logic eng_req,
  output logic cpu_gnt,
  output logic eng_gnt,
  output logic sel_cpu
);

`ifdef SMEM_FAIR_EN
  logic last_cpu;

  always_ff @(posedge clk) begin
    if (reset) last_cpu <= 1'b0;
    else       last_cpu <= cpu_gnt;
  end

  assign eng_gnt = eng_req & (~cpu_req | last_cpu);
`else
  assign eng_gnt = eng_req & ~cpu_req;
`endif

  assign cpu_gnt = cpu_req & ~eng_gnt;
  assign sel_cpu = cpu_gnt;

endmodule

// File: rtl/smem_update_ctrl.sv
// Screen-memory port owner: CPU stores arbitrated against a CLEAR/SCROLL block engine.
// Build option SMEM_FAIR_EN switches the port arbiter to round-robin.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready=1
// CLR_WR | CLEAR: write fill to ptr
// SC_RD  | SCROLL: read ptr+ncols
// SC_WR  | SCROLL: write read data to ptr
// FILL   | SCROLL: write fill to the bottom row
// DONE   | command finished, done pulses next cycle
module smem_update_ctrl
  import smem_pkg::*;
#(
  parameter int Nchars    = NCHARS,
  parameter int smem_size = SMEM_SIZE,
  parameter int ncols     = NCOLS
) (
  input logic              clk,
  input logic              reset,
  smem_update_ctrl_if.slave bus
);

  localparam int ABITS = $clog2(smem_size);
  localparam int CBITS = $clog2(Nchars);
  localparam logic [ABITS-1:0] LAST_ADDR  = ABITS'(smem_size - 1);
  localparam logic [ABITS-1:0] SC_LAST    = ABITS'(smem_size - ncols - 1);
  localparam logic [ABITS-1:0] FILL_START = ABITS'(smem_size - ncols);
  localparam logic [ABITS-1:0] ROW_STEP   = ABITS'(ncols);
  localparam logic [ABITS-1:0] ONE        = ABITS'(1);

  engine_state_t    state, state_nx;
  logic [ABITS-1:0] ptr, ptr_nx;
  logic [CBITS-1:0] fill, hold;
  logic             rd_pend, done_q;
  logic             accept;
  logic             eng_req, eng_we, eng_gnt, cpu_gnt, sel_cpu;
  logic [ABITS-1:0] eng_addr;
  logic [CBITS-1:0] eng_wdata;

  assign accept = bus.cmd_valid && (state == IDLE);

  smem_port_arbiter u_arb (
`ifdef SMEM_FAIR_EN
    .clk     (clk),
    .reset   (reset),
`endif
    .cpu_req (bus.cpu_req & ~reset),
    .eng_req (eng_req & ~reset),
    .cpu_gnt (cpu_gnt),
    .eng_gnt (eng_gnt),
    .sel_cpu (sel_cpu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      fill    <= '0;
      hold    <= '0;
      rd_pend <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      rd_pend <= eng_gnt && (state == SC_RD);
      done_q  <= (state == DONE);
      if (rd_pend) hold <= bus.mem_rdata;
      if (accept)  fill <= bus.cmd_fill;
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    eng_req   = 1'b0;
    eng_we    = 1'b0;
    eng_addr  = ptr;
    eng_wdata = fill;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (op_t'(bus.cmd_op) == OP_SCROLL) ? SC_RD : CLR_WR;
          ptr_nx   = '0;
        end
      end
      CLR_WR, FILL: begin
        eng_req = 1'b1;
        eng_we  = 1'b1;
        if (eng_gnt) begin
          if (ptr == LAST_ADDR) state_nx = DONE;
          else                  ptr_nx   = ptr + ONE;
        end
      end
      SC_RD: begin
        eng_req  = 1'b1;
        eng_addr = ptr + ROW_STEP;
        if (eng_gnt) state_nx = SC_WR;
      end
      SC_WR: begin
        eng_req   = 1'b1;
        eng_we    = 1'b1;
        // read data is only on mem_rdata in the cycle after the read; later the hold copy is used
        eng_wdata = rd_pend ? bus.mem_rdata : hold;
        if (eng_gnt) begin
          if (ptr == SC_LAST) begin
            ptr_nx   = FILL_START;
            state_nx = FILL;
          end else begin
            ptr_nx   = ptr + ONE;
            state_nx = SC_RD;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (sel_cpu) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (eng_gnt) begin
      bus.mem_we    = eng_we;
      bus.mem_addr  = eng_addr;
      bus.mem_wdata = eng_wdata;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_smem_update_ctrl.sv
// Self-checking bench for smem_update_ctrl: behavioural screen memory plus a
// reference of CLEAR/SCROLL results and port timing derived from the command rules.
module tb_smem_update_ctrl;

  localparam int SIZE = 1200;
  localparam int COLS = 40;
  localparam logic [10:0] CPU_ADDR = 11'd5;
  localparam logic [1:0]  CPU_DATA = 2'd1;
`ifdef SMEM_FAIR_EN
  localparam int BURST_DELAY = 5;
`else
  localparam int BURST_DELAY = 10;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  smem_update_ctrl_if bus ();

  smem_update_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [1:0] mem     [SIZE];
  logic [1:0] pre_val [SIZE];
  logic [1:0] exp_mem [SIZE];
  logic       pre_en = 1'b0;

  always @(posedge clk) begin
    if (pre_en) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= pre_val[i];
    end else if (bus.mem_we === 1'b1 && int'(bus.mem_addr) < SIZE) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= (int'(bus.mem_addr) < SIZE) ? mem[bus.mem_addr] : 2'd0;
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < SIZE; i++) pre_val[i] = rnd ? 2'($urandom_range(0, 3)) : 2'(i % 4);
    pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic expect_scroll(input logic [1:0] fill);
    for (int i = 0; i < SIZE; i++) exp_mem[i] = (i < SIZE - COLS) ? pre_val[i + COLS] : fill;
  endtask

  task automatic expect_clear(input logic [1:0] fill);
    for (int i = 0; i < SIZE; i++) exp_mem[i] = fill;
  endtask

  // Called in the accept cycle, just after a rising edge. exp_done counts cycles after accept.
  task automatic run_cmd(input string tag, input logic op, input logic [1:0] fill,
                         input int cpu_at, input int cpu_len, input int exp_done);
    int k, done_cnt, done_at, eng_wr, seq_err, gnt_err, mem_err, next_addr;
    bit req, exp_gnt, prev_cpu, eng_wants;
    logic acc0, busy1;
    k = 0; done_cnt = 0; done_at = -1; eng_wr = 0; seq_err = 0; gnt_err = 0;
    mem_err = 0; next_addr = 0; prev_cpu = 1'b0; acc0 = 1'b0; busy1 = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_fill  = fill;
    while (k <= exp_done + 3) begin
      req = (k >= cpu_at) && (k < cpu_at + cpu_len);
      bus.cpu_req   = req;
      bus.cpu_addr  = CPU_ADDR;
      bus.cpu_wdata = CPU_DATA;
      #1;
      if (k == 0) acc0 = bus.cmd_ready;
      if (k == 1) busy1 = bus.busy;
      eng_wants = (k >= 1) && (k < exp_done - 1);
`ifdef SMEM_FAIR_EN
      exp_gnt = req && !(eng_wants && prev_cpu);
`else
      exp_gnt = req;
`endif
      if (bus.cpu_gnt !== exp_gnt) gnt_err++;
      if (exp_gnt && (bus.mem_we !== 1'b1 || bus.mem_addr !== CPU_ADDR || bus.mem_wdata !== CPU_DATA))
        gnt_err++;
      prev_cpu = exp_gnt;
      if (bus.mem_we === 1'b1 && bus.cpu_gnt === 1'b0) begin
        if (bus.mem_addr !== 11'(next_addr)) seq_err++;
        next_addr++;
        eng_wr++;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      k++;
    end
    bus.cpu_req = 1'b0;
    for (int i = 0; i < SIZE; i++) if (mem[i] !== exp_mem[i]) mem_err++;
    check({tag, ".accepted"}, acc0, 1);
    check({tag, ".busy_next"}, busy1, 1);
    check({tag, ".done_pulses"}, done_cnt, 1);
    check({tag, ".done_cycle"}, done_at, exp_done);
    check({tag, ".engine_writes"}, eng_wr, SIZE);
    check({tag, ".addr_order_errs"}, seq_err, 0);
    check({tag, ".cpu_grant_errs"}, gnt_err, 0);
    check({tag, ".mem_errs"}, mem_err, 0);
    check({tag, ".ready_after"}, bus.cmd_ready, 1);
  endtask

  initial begin
    logic [1:0] f;
    bit found;
    int dn;

    reset = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b0;
    bus.cmd_fill  = 2'd1;
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = CPU_ADDR;
    bus.cpu_wdata = CPU_DATA;
    repeat (3) @(posedge clk);
    #1;
    check("rst.cpu_gnt", bus.cpu_gnt, 0);
    check("rst.mem_we", bus.mem_we, 0);
    check("rst.cmd_ready", bus.cmd_ready, 1);
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    bus.cpu_req = 1'b0;
    reset = 1'b0;
    #1;
    check("rel.cmd_ready", bus.cmd_ready, 1);
    check("rel.busy", bus.busy, 0);
    check("rel.mem_we", bus.mem_we, 0);
    check("rel.mem_addr", bus.mem_addr, 0);
    expect_clear(2'd1);
    run_cmd("clear_after_reset", 1'b0, 2'd1, 0, 0, 1202);

    expect_clear(2'd2);
    run_cmd("clear_fill2", 1'b0, 2'd2, 0, 0, 1202);

    preload(1'b0);
    expect_scroll(2'd3);
    run_cmd("scroll_mod4", 1'b1, 2'd3, 0, 0, 2 * (SIZE - COLS) + COLS + 2);

    preload(1'b1);
    f = 2'($urandom_range(0, 3));
    expect_scroll(f);
    exp_mem[CPU_ADDR] = CPU_DATA;
    run_cmd("scroll_cpu_burst", 1'b1, f, 600, 10, 2 * (SIZE - COLS) + COLS + 2 + BURST_DELAY);

    expect_clear(2'd2);
`ifdef SMEM_FAIR_EN
    exp_mem[CPU_ADDR] = CPU_DATA;
    run_cmd("clear_cpu_flood", 1'b0, 2'd2, 0, 100000, 2401);
`else
    run_cmd("clear_cpu_flood", 1'b0, 2'd2, 0, 200, 1401);
`endif

    preload(1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    bus.cmd_fill  = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (bus.mem_we === 1'b1 && bus.cpu_gnt === 1'b0 && bus.mem_addr === 11'd500) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("abort.reached_500", found, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort.busy", bus.busy, 0);
    check("abort.cmd_ready", bus.cmd_ready, 1);
    check("abort.mem_we", bus.mem_we, 0);
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dn++;
    end
    check("abort.no_done", dn, 0);
    f = 2'($urandom_range(0, 3));
    expect_clear(f);
    run_cmd("clear_after_abort", 1'b0, f, 0, 0, 1202);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
